// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot line encoder and its result FIFO.
package onehot_pkg;

   localparam int NLINES = 16;
   localparam int IDX_W  = 4;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_NONE  = 2'b01;
   localparam logic [1:0] ST_MULTI = 2'b10;

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [1:0]       status;
   } result_t;

endpackage

// File: rtl/onehot_enc_fifo.sv
// Small result FIFO holding encoded samples; head reads as zero when empty.
module onehot_enc_fifo
   import onehot_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  logic    pop,
   input  result_t wr_data,
   output result_t rd_data,
   output logic    full,
   output logic    empty
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   result_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/onehot_index_encoder.sv
// Converts a 16-line decoder vector back to an index with OK/NONE/MULTI status, buffered.
// Optional error counter enabled by defining ONEHOT_ENC_ERRCNT_EN.
module onehot_index_encoder
   import onehot_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NLINES-1:0] in_lines,
`ifdef ONEHOT_ENC_ERRCNT_EN
   input  logic              err_clr,
   output logic [7:0]        err_cnt,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [1:0]        out_status
);

   result_t enc;
   result_t head;
   logic    push;
   logic    pop;
   logic    full;
   logic    empty;

   // Lowest set bit wins, so scanning downward leaves the smallest index.
   always_comb begin
      enc.index  = '0;
      enc.status = ST_OK;
      for (int k = NLINES - 1; k >= 0; k--) begin
         if (in_lines[k]) enc.index = IDX_W'(k);
      end
      if (in_lines == '0)
         enc.status = ST_NONE;
      else if ((in_lines & (in_lines - NLINES'(1))) != '0)
         enc.status = ST_MULTI;
   end

   assign in_ready   = ~full;
   assign out_valid  = ~empty;
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign out_index  = head.index;
   assign out_status = head.status;

   onehot_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (enc),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

`ifdef ONEHOT_ENC_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (push && (enc.status != ST_OK) && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Directed self-checking bench for onehot_index_encoder (DEPTH=2).
module tb_onehot_index_encoder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_lines;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_index;
   logic [1:0]  out_status;
`ifdef ONEHOT_ENC_ERRCNT_EN
   logic        err_clr;
   logic [7:0]  err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   onehot_index_encoder #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_lines   (in_lines),
`ifdef ONEHOT_ENC_ERRCNT_EN
      .err_clr    (err_clr),
      .err_cnt    (err_cnt),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_status (out_status)
   );

   task automatic test_reset;
      rst_n = 1'b1; in_valid = 1'b0; in_lines = '0; out_ready = 1'b0;
`ifdef ONEHOT_ENC_ERRCNT_EN
      err_clr = 1'b0;
`endif
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_out_index got %0d want 0", out_index); end
      checks++; if (out_status !== 2'b00) begin errors++; $display("FAIL reset_out_status got %b want 00", out_status); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %0b want 0", out_valid); end
`ifdef ONEHOT_ENC_ERRCNT_EN
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
`endif
   endtask

   task automatic test_single;
      in_valid = 1'b1; in_lines = 16'h0200; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
      checks++; if (out_index !== 4'd9) begin errors++; $display("FAIL single_index got %0d want 9", out_index); end
      checks++; if (out_status !== 2'b00) begin errors++; $display("FAIL single_status got %b want 00", out_status); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %0b want 0", out_valid); end
   endtask

   task automatic test_errors;
      in_valid = 1'b1; in_lines = 16'h0000; out_ready = 1'b1;
      @(negedge clk);
      in_lines = 16'h8010;
      checks++; if ({out_valid, out_index, out_status} !== {1'b1, 4'd0, 2'b01})
         begin errors++; $display("FAIL err_none got v%0b i%0d s%b want v1 i0 s01", out_valid, out_index, out_status); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({out_valid, out_index, out_status} !== {1'b1, 4'd4, 2'b10})
         begin errors++; $display("FAIL err_multi got v%0b i%0d s%b want v1 i4 s10", out_valid, out_index, out_status); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_drained got %0b want 0", out_valid); end
`ifdef ONEHOT_ENC_ERRCNT_EN
      checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL err_cnt got %0d want 2", err_cnt); end
      err_clr = 1'b1; in_valid = 1'b1; in_lines = 16'h0000;
      @(negedge clk);
      err_clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_clr_priority got %0d want 0", err_cnt); end
      @(negedge clk);
`endif
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0; in_valid = 1'b1; in_lines = 16'h0001;
      @(negedge clk);
      in_lines = 16'h0004;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0b want 1", in_ready); end
      @(negedge clk);
      in_lines = 16'h0008;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %0b want 0", in_ready); end
      @(negedge clk);
      checks++; if ({out_valid, out_index, in_ready} !== {1'b1, 4'd0, 1'b0})
         begin errors++; $display("FAIL bp_hold got v%0b i%0d r%0b want v1 i0 r0", out_valid, out_index, in_ready); end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++; if ({out_valid, out_index, in_ready} !== {1'b1, 4'd2, 1'b1})
         begin errors++; $display("FAIL bp_second got v%0b i%0d r%0b want v1 i2 r1", out_valid, out_index, in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_third_dropped got %0b want 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] lines_q [4] = '{16'h0040, 16'h0040, 16'h0080, 16'h0100};
      logic [3:0]  idx_q   [4] = '{4'd4, 4'd5, 4'd6, 4'd7};
      logic        rdy_q   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      out_ready = 1'b0; in_valid = 1'b1; in_lines = 16'h0010;
      @(negedge clk);
      in_lines = 16'h0020;
      @(negedge clk);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_lines = lines_q[c];
         checks++; if ({out_valid, out_index, in_ready} !== {1'b1, idx_q[c], rdy_q[c]})
            begin errors++; $display("FAIL b2b_cycle%0d got v%0b i%0d r%0b want v1 i%0d r%0b", c, out_valid, out_index, in_ready, idx_q[c], rdy_q[c]); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if ({out_valid, out_index} !== {1'b1, 4'd8})
         begin errors++; $display("FAIL b2b_last got v%0b i%0d want v1 i8", out_valid, out_index); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b want 0", out_valid); end
   endtask

   task automatic test_sweep;
      logic [15:0] one;
      one = 16'h0001; out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_lines = one << k;
         @(negedge clk);
         checks++; if ({out_valid, out_index, out_status, in_ready} !== {1'b1, 4'(k), 2'b00, 1'b1})
            begin errors++; $display("FAIL sweep_%0d got v%0b i%0d s%b r%0b want v1 i%0d s00 r1", k, out_valid, out_index, out_status, in_ready, k); end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drained got %0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0; in_valid = 1'b1; in_lines = 16'h0002;
      @(negedge clk);
      in_lines = 16'h0004;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({out_valid, in_ready} !== {1'b1, 1'b0})
         begin errors++; $display("FAIL rst_mid_full got v%0b r%0b want v1 r0", out_valid, in_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, in_ready, out_index} !== {1'b0, 1'b1, 4'd0})
         begin errors++; $display("FAIL rst_mid_async got v%0b r%0b i%0d want v0 r1 i0", out_valid, in_ready, out_index); end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_lines = 16'h4000;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({out_valid, out_index, out_status} !== {1'b1, 4'd14, 2'b00})
         begin errors++; $display("FAIL rst_mid_new got v%0b i%0d s%b want v1 i14 s00", out_valid, out_index, out_status); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_replay got %0b want 0", out_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_sweep();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
